// File: rtl/isr_pkg.sv
// rtl/isr_pkg.sv - shared types and constants for the interrupt entry/return sequencer
package isr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    JUMP,
    SERVICE,
    RETURN
  } isr_state_t;

  localparam int         ISR_DEPTH_MAX = 4;
  localparam logic [7:0] RESET_PC      = 8'h00;

endpackage

// File: rtl/isr_stack.sv
// rtl/isr_stack.sv - saved-PC LIFO; entry 0 is always the top, entries shift on push/pop
module isr_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] depth,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count;

  assign top   = mem[0];
  assign depth = count;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Push at full and pop at empty are silently dropped.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else if (push && !full) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      mem[DEPTH-1] <= '0;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/isr_sequencer.sv
// rtl/isr_sequencer.sv - interrupt entry/return FSM; nested interrupts when ISR_NEST_EN is defined
module isr_sequencer
  import isr_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            i_pending,
  input  logic [PC_W-1:0] vector,
  input  logic [PC_W-1:0] pc,
  input  logic            instr_done,
  input  logic            reti,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_next,
  output logic            i_clr,
  output logic            int_en,
  output logic            in_isr,
  output logic [2:0]      depth
);

  localparam int NEST_D  = (DEPTH > ISR_DEPTH_MAX) ? ISR_DEPTH_MAX : DEPTH;
`ifdef ISR_NEST_EN
  localparam int STACK_D = NEST_D;
`else
  localparam int STACK_D = (NEST_D < 1) ? NEST_D : 1;
`endif
  localparam int CW = $clog2(STACK_D + 1);

  isr_state_t      state, state_nxt;
  logic [PC_W-1:0] vec_q;
  logic [PC_W-1:0] top;
  logic [CW-1:0]   stk_depth;
  logic            full, empty, push, pop;

  isr_stack #(.W(PC_W), .DEPTH(STACK_D), .CW(CW)) u_stack (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (pc),
    .top   (top),
    .depth (stk_depth),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      vec_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == SAVE) vec_q <= vector;
    end
  end

  // reti is checked before i_pending so a return always wins a shared boundary.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE:    if (instr_done && i_pending) state_nxt = SAVE;
      SAVE: begin
        push      = !full;
        state_nxt = JUMP;
      end
      JUMP:    state_nxt = SERVICE;
      SERVICE: begin
        if (instr_done && reti) state_nxt = RETURN;
`ifdef ISR_NEST_EN
        else if (instr_done && i_pending && !full) state_nxt = SAVE;
`endif
      end
      RETURN: begin
        pop       = 1'b1;
        state_nxt = (stk_depth > CW'(1)) ? SERVICE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never directly on inputs.
  always_comb begin
    pc_load = 1'b0;
    i_clr   = 1'b0;
    pc_next = PC_W'(RESET_PC);
    int_en  = 1'b0;
    case (state)
      IDLE:    int_en = 1'b1;
      JUMP: begin
        pc_load = 1'b1;
        i_clr   = 1'b1;
        pc_next = vec_q;
      end
      RETURN: begin
        pc_load = 1'b1;
        pc_next = top;
      end
`ifdef ISR_NEST_EN
      SERVICE: int_en = !full;
`endif
      default: ;
    endcase
  end

  assign in_isr = !empty;
  assign depth  = 3'(stk_depth);

endmodule

// File: tb/tb_isr_sequencer.sv
// tb/tb_isr_sequencer.sv - directed self-checking bench for isr_sequencer (both ISR_NEST_EN builds)
module tb_isr_sequencer;

`ifdef ISR_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       i_pending = 1'b0;
  logic [7:0] vector = '0;
  logic [7:0] pc = '0;
  logic       instr_done = 1'b0;
  logic       reti = 1'b0;
  logic       pc_load;
  logic [7:0] pc_next;
  logic       i_clr;
  logic       int_en;
  logic       in_isr;
  logic [2:0] depth;

  int n_checks = 0;
  int n_fail   = 0;

  isr_sequencer #(.PC_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .i_pending  (i_pending),
    .vector     (vector),
    .pc         (pc),
    .instr_done (instr_done),
    .reti       (reti),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .i_clr      (i_clr),
    .int_en     (int_en),
    .in_isr     (in_isr),
    .depth      (depth)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: boundary with pending interrupt, then run until SERVICE.
  task automatic enter_isr(input logic [7:0] p, input logic [7:0] v);
    pc = p; vector = v; i_pending = 1'b1; instr_done = 1'b1;
    tick();
    instr_done = 1'b0; i_pending = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    tick();
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL reset_pc_load got %b exp 0", pc_load); end
    n_checks++; if (pc_next !== 8'h00) begin n_fail++; $display("FAIL reset_pc_next got %h exp 00", pc_next); end
    n_checks++; if (i_clr !== 1'b0) begin n_fail++; $display("FAIL reset_i_clr got %b exp 0", i_clr); end
    n_checks++; if (int_en !== 1'b1) begin n_fail++; $display("FAIL reset_int_en got %b exp 1", int_en); end
    n_checks++; if (in_isr !== 1'b0) begin n_fail++; $display("FAIL reset_in_isr got %b exp 0", in_isr); end
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth got %0d exp 0", depth); end
  endtask

  task automatic test_single();
    pc = 8'h20; vector = 8'h04; i_pending = 1'b1; instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL single_save_pc_load got %b exp 0", pc_load); end
    n_checks++; if (int_en !== 1'b0) begin n_fail++; $display("FAIL single_save_int_en got %b exp 0", int_en); end
    tick();
    n_checks++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL single_jump_pc_load got %b exp 1", pc_load); end
    n_checks++; if (i_clr !== 1'b1) begin n_fail++; $display("FAIL single_jump_i_clr got %b exp 1", i_clr); end
    n_checks++; if (pc_next !== 8'h04) begin n_fail++; $display("FAIL single_jump_pc_next got %h exp 04", pc_next); end
    n_checks++; if (depth !== 3'd1) begin n_fail++; $display("FAIL single_jump_depth got %0d exp 1", depth); end
    i_pending = 1'b0;
    tick();
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL single_svc_pc_load got %b exp 0", pc_load); end
    n_checks++; if (i_clr !== 1'b0) begin n_fail++; $display("FAIL single_svc_i_clr got %b exp 0", i_clr); end
    n_checks++; if (int_en !== NEST) begin n_fail++; $display("FAIL single_svc_int_en got %b exp %b", int_en, NEST); end
    n_checks++; if (in_isr !== 1'b1) begin n_fail++; $display("FAIL single_svc_in_isr got %b exp 1", in_isr); end
    reti = 1'b1; instr_done = 1'b1;
    tick();
    reti = 1'b0; instr_done = 1'b0;
    n_checks++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL single_ret_pc_load got %b exp 1", pc_load); end
    n_checks++; if (pc_next !== 8'h20) begin n_fail++; $display("FAIL single_ret_pc_next got %h exp 20", pc_next); end
    n_checks++; if (int_en !== 1'b0) begin n_fail++; $display("FAIL single_ret_int_en got %b exp 0", int_en); end
    tick();
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL single_idle_pc_load got %b exp 0", pc_load); end
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL single_idle_depth got %0d exp 0", depth); end
    n_checks++; if (int_en !== 1'b1) begin n_fail++; $display("FAIL single_idle_int_en got %b exp 1", int_en); end
  endtask

  task automatic test_non_boundary();
    pc = 8'h50; vector = 8'h08; i_pending = 1'b1; instr_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL nonbnd_pc_load cyc %0d got %b exp 0", i, pc_load); end
      n_checks++; if (int_en !== 1'b1) begin n_fail++; $display("FAIL nonbnd_int_en cyc %0d got %b exp 1", i, int_en); end
    end
    i_pending = 1'b0;
    n_checks++; if (in_isr !== 1'b0) begin n_fail++; $display("FAIL nonbnd_in_isr got %b exp 0", in_isr); end
  endtask

  task automatic test_race();
    enter_isr(8'h30, 8'h08);
    n_checks++; if (depth !== 3'd1) begin n_fail++; $display("FAIL race_depth_in got %0d exp 1", depth); end
    reti = 1'b1; i_pending = 1'b1; instr_done = 1'b1; pc = 8'h31; vector = 8'h0C;
    tick();
    reti = 1'b0; instr_done = 1'b0;
    n_checks++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL race_ret_pc_load got %b exp 1", pc_load); end
    n_checks++; if (pc_next !== 8'h30) begin n_fail++; $display("FAIL race_ret_pc_next got %h exp 30", pc_next); end
    tick();
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL race_idle_depth got %0d exp 0", depth); end
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL race_idle_pc_load got %b exp 0", pc_load); end
    n_checks++; if (int_en !== 1'b1) begin n_fail++; $display("FAIL race_idle_int_en got %b exp 1", int_en); end
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0; i_pending = 1'b0;
    tick();
    n_checks++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL race_reentry_pc_load got %b exp 1", pc_load); end
    n_checks++; if (pc_next !== 8'h0C) begin n_fail++; $display("FAIL race_reentry_pc_next got %h exp 0c", pc_next); end
    tick();
    reti = 1'b1; instr_done = 1'b1;
    tick();
    reti = 1'b0; instr_done = 1'b0;
    n_checks++; if (pc_next !== 8'h31) begin n_fail++; $display("FAIL race_ret2_pc_next got %h exp 31", pc_next); end
    tick();
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL race_end_depth got %0d exp 0", depth); end
  endtask

`ifdef ISR_NEST_EN
  task automatic test_nesting();
    logic [7:0] exp_pc;
    for (int k = 0; k < 4; k++) begin
      pc = 8'h10 + 8'(k); vector = 8'h40 + 8'(k); i_pending = 1'b1; instr_done = 1'b1;
      tick();
      instr_done = 1'b0; i_pending = 1'b0;
      tick();
      exp_pc = 8'h40 + 8'(k);
      n_checks++; if (pc_next !== exp_pc) begin n_fail++; $display("FAIL nest_jump%0d_pc_next got %h exp %h", k, pc_next, exp_pc); end
      tick();
      n_checks++; if (depth !== 3'(k + 1)) begin n_fail++; $display("FAIL nest_depth%0d got %0d exp %0d", k, depth, k + 1); end
    end
    n_checks++; if (int_en !== 1'b0) begin n_fail++; $display("FAIL nest_full_int_en got %b exp 0", int_en); end
    pc = 8'h77; vector = 8'h7F; i_pending = 1'b1; instr_done = 1'b1;
    tick();
    instr_done = 1'b0; i_pending = 1'b0;
    tick();
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL nest_full_pc_load got %b exp 0", pc_load); end
    n_checks++; if (depth !== 3'd4) begin n_fail++; $display("FAIL nest_full_depth got %0d exp 4", depth); end
    for (int k = 0; k < 4; k++) begin
      reti = 1'b1; instr_done = 1'b1;
      tick();
      reti = 1'b0; instr_done = 1'b0;
      exp_pc = 8'h13 - 8'(k);
      n_checks++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL nest_ret%0d_pc_load got %b exp 1", k, pc_load); end
      n_checks++; if (pc_next !== exp_pc) begin n_fail++; $display("FAIL nest_ret%0d_pc_next got %h exp %h", k, pc_next, exp_pc); end
      tick();
      n_checks++; if (depth !== 3'(3 - k)) begin n_fail++; $display("FAIL nest_ret%0d_depth got %0d exp %0d", k, depth, 3 - k); end
    end
    n_checks++; if (int_en !== 1'b1) begin n_fail++; $display("FAIL nest_end_int_en got %b exp 1", int_en); end
  endtask
`else
  task automatic test_no_nesting();
    enter_isr(8'h60, 8'h18);
    i_pending = 1'b1; instr_done = 1'b1; pc = 8'h61; vector = 8'h1C;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL nonest_pc_load cyc %0d got %b exp 0", i, pc_load); end
      n_checks++; if (int_en !== 1'b0) begin n_fail++; $display("FAIL nonest_int_en cyc %0d got %b exp 0", i, int_en); end
      n_checks++; if (depth !== 3'd1) begin n_fail++; $display("FAIL nonest_depth cyc %0d got %0d exp 1", i, depth); end
    end
    i_pending = 1'b0; reti = 1'b1;
    tick();
    reti = 1'b0; instr_done = 1'b0;
    n_checks++; if (pc_next !== 8'h60) begin n_fail++; $display("FAIL nonest_ret_pc_next got %h exp 60", pc_next); end
    tick();
    n_checks++; if (int_en !== 1'b1) begin n_fail++; $display("FAIL nonest_end_int_en got %b exp 1", int_en); end
  endtask
`endif

  task automatic test_reset_mid();
    pc = 8'h70; vector = 8'h24; i_pending = 1'b1; instr_done = 1'b1;
    tick();
    instr_done = 1'b0; i_pending = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL rstmid_pc_load got %b exp 0", pc_load); end
    n_checks++; if (i_clr !== 1'b0) begin n_fail++; $display("FAIL rstmid_i_clr got %b exp 0", i_clr); end
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL rstmid_depth got %0d exp 0", depth); end
    n_checks++; if (int_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_int_en got %b exp 1", int_en); end
    tick();
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_pc_load got %b exp 0", pc_load); end
    enter_isr(8'h71, 8'h28);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++; if (in_isr !== 1'b0) begin n_fail++; $display("FAIL rstsvc_in_isr got %b exp 0", in_isr); end
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL rstsvc_depth got %0d exp 0", depth); end
    reti = 1'b1; instr_done = 1'b1;
    tick();
    reti = 1'b0; instr_done = 1'b0;
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL reti_idle_pc_load got %b exp 0", pc_load); end
    tick();
    n_checks++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL reti_idle_pc_load2 got %b exp 0", pc_load); end
    n_checks++; if (depth !== 3'd0) begin n_fail++; $display("FAIL reti_idle_depth got %0d exp 0", depth); end
    n_checks++; if (int_en !== 1'b1) begin n_fail++; $display("FAIL reti_idle_int_en got %b exp 1", int_en); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_non_boundary();
    test_race();
`ifdef ISR_NEST_EN
    test_nesting();
`else
    test_no_nesting();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
